// File: rtl/clkgen_multi.sv
// rtl/clkgen_multi.sv - multi-channel programmable clock divider with glitch-free ratio change
//
// Purpose: NCH independent divide-by-2*(act+1) channels, all clocked by CLK_24M.
// Each channel has 50% duty and edge strobes. Each channel has a pending half-period
// register. The pending value only takes effect at the end of a high phase, so a
// ratio change never produces a runt pulse.
//
// Ports:
//   CLK_24M  in   sole clock
//   nRESETP  in   asynchronous active-low reset
//   HALF     in   NCH*CNTW  half-period minus one, channel k at [k*CNTW +: CNTW]
//   PHASE    in   NCH*CNTW  counter preload applied on SYNC
//   EN       in   NCH       per-channel run enable
//   LOAD     in   strobe, captures HALF into every pending register
//   SYNC     in   strobe, realigns every channel
//   CLK_OUT  out  NCH       divided clocks (registered)
//   CE_RISE  out  NCH       high in the first cycle of each CLK_OUT high level
//   CE_FALL  out  NCH       high in the first cycle of each CLK_OUT low level
//   BUSY     out  NCH       a loaded half-period is waiting to be applied
module clkgen_multi #(
  parameter int NCH  = 4,
  parameter int CNTW = 8,
  parameter logic [NCH*CNTW-1:0] HALF_RST = {NCH{8'd0}}
) (
  input  logic                 CLK_24M,
  input  logic                 nRESETP,
  input  logic [NCH*CNTW-1:0]  HALF,
  input  logic [NCH*CNTW-1:0]  PHASE,
  input  logic [NCH-1:0]       EN,
  input  logic                 LOAD,
  input  logic                 SYNC,
  output logic [NCH-1:0]       CLK_OUT,
  output logic [NCH-1:0]       CE_RISE,
  output logic [NCH-1:0]       CE_FALL,
  output logic [NCH-1:0]       BUSY
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] act;
    logic [CNTW-1:0] pend;
    logic            pend_valid;
    logic            clk_q;
    logic            rise_q;
    logic            fall_q;

    logic [CNTW-1:0] half_k;
    logic [CNTW-1:0] phase_k;
    logic [CNTW-1:0] act_sync;
    logic            run;
    logic            tc;

    assign half_k  = HALF[k*CNTW +: CNTW];
    assign phase_k = PHASE[k*CNTW +: CNTW];

    // Half-period in force after a SYNC. A simultaneous LOAD bypasses the
    // pending register. Otherwise an outstanding pending value is applied now.
    assign act_sync = LOAD ? half_k : (pend_valid ? pend : act);

    // A disabled channel finishes its high phase before it freezes.
    assign run = EN[k] | clk_q;
    assign tc  = (cnt == act);

    always_ff @(posedge CLK_24M or negedge nRESETP) begin
      if (!nRESETP) begin
        cnt        <= '0;
        act        <= HALF_RST[k*CNTW +: CNTW];
        pend       <= '0;
        pend_valid <= 1'b0;
        clk_q      <= 1'b0;
        rise_q     <= 1'b0;
        fall_q     <= 1'b0;
      end else if (SYNC) begin
        act        <= act_sync;
        pend_valid <= 1'b0;
        if (LOAD) begin
          pend <= half_k;
        end
        // Clamp the preload so the counter never starts beyond its terminal count.
        cnt    <= (phase_k > act_sync) ? act_sync : phase_k;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        if (run && tc) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          rise_q <= ~clk_q;
          fall_q <= clk_q;
          // Apply a pending ratio only at the 1->0 boundary.
          if (clk_q && pend_valid) begin
            act        <= pend;
            pend_valid <= 1'b0;
          end
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          cnt    <= run ? cnt + 1'b1 : '0;
        end
        // A new LOAD wins over a boundary application in the same cycle.
        if (LOAD) begin
          pend       <= half_k;
          pend_valid <= 1'b1;
        end
      end
    end

    assign CLK_OUT[k] = clk_q;
    assign CE_RISE[k] = rise_q;
    assign CE_FALL[k] = fall_q;
    assign BUSY[k]    = pend_valid;
  end

endmodule

// File: doc/clkgen_multi.md
CLKGEN_MULTI -- requirements
Module: clkgen_multi

Interface
REQ-001 SHALL: parameter NCH, default 4, number of independent divider channels.
REQ-002 SHALL: parameter CNTW, default 8, width of the per-channel half-period and phase fields.
REQ-003 SHALL: parameter HALF_RST, default {NCH{8'd0}}, per-channel half-period value loaded at reset (0 = divide-by-2).
REQ-004 SHALL: CLK_24M  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL: nRESETP  in  1  reset, asynchronous assert, active-low; synchronous release on CLK_24M.
REQ-006 SHALL: HALF  in  NCH*CNTW  requested half-period minus one, per channel; channel k uses bits [k*CNTW +: CNTW].
REQ-007 SHALL: PHASE  in  NCH*CNTW  counter preload applied on SYNC, per channel.
REQ-008 SHALL: EN  in  NCH  per-channel run enable.
REQ-009 SHALL: LOAD  in  1  one-cycle strobe; captures HALF into every channel's pending register.
REQ-010 SHALL: SYNC  in  1  one-cycle strobe; realigns all channels.
REQ-011 SHALL: CLK_OUT  out  NCH  divided clock per channel, registered.
REQ-012 SHALL: CE_RISE  out  NCH  one-cycle pulse, high in the cycle CLK_OUT[k] goes 0->1.
REQ-013 SHALL: CE_FALL  out  NCH  one-cycle pulse, high in the cycle CLK_OUT[k] goes 1->0.
REQ-014 SHALL: BUSY  out  NCH  high while channel k holds a pending, not-yet-applied HALF value.

Function
REQ-015 SHALL: each channel keeps cnt[CNTW], an active half-period act[CNTW], pend[CNTW] and a pend_valid flag.
REQ-016 SHALL: while EN[k]=1, cnt==act -> cnt<=0 and CLK_OUT toggles; otherwise cnt<=cnt+1; period = 2*(act+1) cycles, 50% duty.
REQ-017 SHALL: CE_RISE/CE_FALL are registered with CLK_OUT, i.e. asserted in the same cycle the new CLK_OUT level first appears.
REQ-018 SHALL: LOAD -> pend<=HALF field and pend_valid<=1 for all channels; a later LOAD before application overwrites pend.
REQ-019 SHALL: pending value applied only at a period boundary (the terminal count at which CLK_OUT toggles 1->0): act<=pend, pend_valid<=0 -> no runt pulse, glitch-free ratio change.
REQ-020 SHALL: SYNC -> for every channel: CLK_OUT<=0, CE_RISE/CE_FALL<=0, cnt<=min(PHASE field, new act), and a valid pending value is applied immediately.
REQ-021 SHALL: SYNC and LOAD in the same cycle -> HALF applied directly to act (pend_valid stays 0), then SYNC preload uses the new act for the clamp.
REQ-022 SHALL: EN[k] falling while CLK_OUT[k]=1 -> channel keeps counting until the 1->0 toggle, then freezes with CLK_OUT=0, cnt=0.
REQ-023 SHALL: EN[k]=0 with CLK_OUT[k]=0 -> cnt held at 0, no CE pulses; pending application deferred until the channel runs again or SYNC.
REQ-024 SHALL: EN[k] rising -> first CE_RISE after act+1 cycles (counter restarts from 0).
REQ-025 SHALL: act=0 gives CLK_OUT toggling every cycle (CLK_24M/2); act=2^CNTW-1 is legal and no counter wrap beyond act occurs.
REQ-026 SHALL: channels are fully independent except for shared LOAD and SYNC.
REQ-027 SHALL: BUSY[k] = pend_valid[k], combinational from the register.

Reset
REQ-028 SHALL: nRESETP low -> immediately cnt=0, CLK_OUT=0, CE_RISE=0, CE_FALL=0, act=HALF_RST field, pend=0, pend_valid=0, BUSY=0.
REQ-029 SHALL: reset mid-period truncates the current output pulse; no pending value survives reset.
REQ-030 SHALL: first CLK_24M edge after release counts from cnt=0 if EN[k]=1.

Verification
REQ-031 SHALL: reset, HALF_RST=0, EN=all 1 -> CLK_OUT[0] toggles every cycle, CE_RISE every 2nd cycle.
REQ-032 SHALL: LOAD with HALF[0]=3 while act=0 -> BUSY[0] high until next 1->0 toggle, then period 8 cycles, high 4 / low 4, no pulse shorter than 1 cycle.
REQ-033 SHALL: act=5 on ch0/ch1, SYNC with PHASE0=0, PHASE1=3 -> ch1 CE_RISE exactly 3 cycles before ch0 CE_RISE every 12 cycles; PHASE1=9 clamps to 5.
REQ-034 SHALL: EN[2] dropped 1 cycle after CLK_OUT[2] rises, act=4 -> CLK_OUT[2] stays high 4 more cycles, falls with CE_FALL, then constant 0.
REQ-035 SHALL: SYNC+LOAD same cycle, HALF=1 -> all outputs 0, period 4 starting immediately, BUSY never asserted.
REQ-036 SHALL: nRESETP pulsed low mid-high-phase -> CLK_OUT, CE_* drop to 0 asynchronously, act returns to HALF_RST.
